cordic_lane_scheduler: RTL
==========================

Name: cordic_lane_scheduler

Overview:
Time-multiplexes one shared CORDIC core between the three stage-1 lanes (one, two, three). It captures the three CORDIC-bound operands on start and issues them to the core in order one, two, three using a start/done handshake. It collects the three results and presents them together with a one-cycle done pulse. A watchdog detects a core that never answers and flushes it.

Parameters:
CORDIC_DATA_WIDTH, 22, width of CORDIC operands and results
TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT for one lane before timeout
CNT_WIDTH, 7, watchdog counter width; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock, reset is asynchronous and active-low
clk_en  input  1  global enable; when low, all registers hold
start  input  1  request to process one operand triple; sampled only in IDLE
x_one  input  CORDIC_DATA_WIDTH  lane one operand
x_two  input  CORDIC_DATA_WIDTH  lane two operand
x_three  input  CORDIC_DATA_WIDTH  lane three operand
busy  output  1  high in every state except IDLE
cordic_start  output  1  one-cycle issue strobe to the shared core
cordic_x  output  CORDIC_DATA_WIDTH  operand presented to the core
cordic_flush  output  1  one-cycle core flush strobe on timeout
cordic_done  input  1  core result-valid strobe
cordic_result  input  CORDIC_DATA_WIDTH  core result
done  output  1  one-cycle pulse; res_* are valid
res_one  output  CORDIC_DATA_WIDTH  lane one result
res_two  output  CORDIC_DATA_WIDTH  lane two result
res_three  output  CORDIC_DATA_WIDTH  lane three result
error  output  1  sticky timeout flag

Behaviour:
- Reset (rst low, asynchronous): state is IDLE, lane index is 0, watchdog is 0. All outputs are 0, including the captured operands, res_*, and error.
- clk_en low: the FSM, counters, and all output registers hold their values, including any strobes. The shared core runs on the same clk_en.
- States are IDLE, ISSUE, WAIT, and DONE. Every output is registered.
- IDLE:
  - start=1 captures x_one, x_two, and x_three into operand registers.
  - It clears error, sets the lane index to 0, and moves to ISSUE.
  - start in any other state is ignored. It is not queued.
- ISSUE:
  - cordic_start=1 for exactly this cycle.
  - cordic_x = operand[lane], held stable until the next ISSUE.
  - The watchdog is cleared and the FSM moves to WAIT.
- WAIT:
  - cordic_done=1 stores cordic_result into res_[lane].
  - If lane<2, lane increments and the FSM moves to ISSUE. If lane=2, it moves to DONE.
  - cordic_done is ignored in IDLE, ISSUE, and DONE.
- Timeout:
  - In WAIT, the watchdog increments every enabled cycle without cordic_done.
  - When the watchdog reaches TIMEOUT_CYCLES-1 and cordic_done=0, res_[lane] is set to 0, error is set to 1, and cordic_flush=1 for that cycle.
  - The FSM then advances exactly as it would on a done.
  - If cordic_done arrives in the same cycle as the timeout, the done wins: no error and no flush.
- DONE: done=1 for one cycle, then the FSM returns to IDLE. res_* hold their values until the next capture overwrites them lane by lane.
- Latency:
  - Let the core answer D cycles after cordic_start (D≥1), with start accepted at cycle 0.
  - cordic_start is high at cycles 1, 2+D, and 3+2D.
  - done is high at cycle 4+3D.
  - A back-to-back start is accepted no earlier than the cycle after done.
- Reset mid-operation: the transaction is aborted and no done is issued. The core is not flushed by this block.
- error stays set through DONE and IDLE, and clears only when the next start is accepted.

Test Plan:
- Core model with D=16; start with x_one=0x00100, x_two=0x3FFFF, x_three=0x2AAAA; the model returns x+1 → cordic_start at cycles 1, 18, 35; done at cycle 52; res = 0x00101, 0x40000, 0x2AAAB; error=0.
- start held high for 100 cycles → exactly two transactions; only three cordic_start pulses occur before the first done.
- Model never answers lane two, with TIMEOUT_CYCLES=64 → cordic_flush pulses once, 64 cycles after lane two's issue; res_two=0; lanes one and three are correct; done fires; error=1 until the next start.
- Model asserts cordic_done exactly on the timeout cycle → the result is stored, no flush, error=0.
- clk_en low for 10 cycles while in WAIT → watchdog and outputs freeze; done is delayed by exactly 10 cycles and results are unchanged.
- rst asserted low in the middle of lane two's WAIT → busy, done, cordic_start, and res_* are 0 immediately (asynchronously); after release the block is in IDLE and a new start completes normally.

Source files
------------

// File: rtl/cordic_lane_scheduler.sv
// cordic_lane_scheduler
//
// Shares one CORDIC core between three lanes (one, two, three). On start the
// three operands are captured and issued to the core one after another with a
// start/done handshake. The three results are returned together with a
// single-cycle done pulse. A watchdog flushes a core that never answers. A lane
// that times out returns a result of zero and sets the sticky error flag.
//
// Ports
//   clk            system clock
//   rst            asynchronous reset, active low
//   clk_en         global enable; every register holds while low
//   start          request to process one operand triple (sampled in IDLE only)
//   x_one/two/three lane operands
//   busy           high whenever the scheduler is not idle
//   cordic_start   one-cycle issue strobe to the shared core
//   cordic_x       operand presented to the core, stable until the next issue
//   cordic_flush   one-cycle flush strobe when a lane times out
//   cordic_done    core result-valid strobe
//   cordic_result  core result
//   done           one-cycle pulse; res_* valid
//   res_one/two/three lane results
//   error          sticky timeout flag, cleared by the next accepted start
//
// State table
//   state | meaning
//   IDLE  | waiting for start; results and error held
//   ISSUE | cordic_start high, cordic_x carries operand[lane]
//   WAIT  | waiting for cordic_done or watchdog timeout for the current lane
//   DONE  | done high for one cycle, back to IDLE next

module cordic_lane_scheduler #(
  parameter int CORDIC_DATA_WIDTH = 22,
  parameter int TIMEOUT_CYCLES    = 64,
  parameter int CNT_WIDTH         = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic                         start,
  input  logic [CORDIC_DATA_WIDTH-1:0] x_one,
  input  logic [CORDIC_DATA_WIDTH-1:0] x_two,
  input  logic [CORDIC_DATA_WIDTH-1:0] x_three,
  output logic                         busy,
  output logic                         cordic_start,
  output logic [CORDIC_DATA_WIDTH-1:0] cordic_x,
  output logic                         cordic_flush,
  input  logic                         cordic_done,
  input  logic [CORDIC_DATA_WIDTH-1:0] cordic_result,
  output logic                         done,
  output logic [CORDIC_DATA_WIDTH-1:0] res_one,
  output logic [CORDIC_DATA_WIDTH-1:0] res_two,
  output logic [CORDIC_DATA_WIDTH-1:0] res_three,
  output logic                         error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] WDOG_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] WDOG_ONE  = CNT_WIDTH'(1);
  localparam logic [1:0]           LANE_LAST = 2'd2;

  state_t state_q;
  state_t state_d;

  logic [1:0]                   lane_q;
  logic [1:0]                   lane_d;
  logic [CNT_WIDTH-1:0]         wdog_q;
  logic [CNT_WIDTH-1:0]         wdog_d;
  logic [CORDIC_DATA_WIDTH-1:0] op_one_q;
  logic [CORDIC_DATA_WIDTH-1:0] op_two_q;
  logic [CORDIC_DATA_WIDTH-1:0] op_three_q;
  logic [CORDIC_DATA_WIDTH-1:0] op_one_d;
  logic [CORDIC_DATA_WIDTH-1:0] op_two_d;
  logic [CORDIC_DATA_WIDTH-1:0] op_three_d;

  logic                         busy_d;
  logic                         cordic_start_d;
  logic [CORDIC_DATA_WIDTH-1:0] cordic_x_d;
  logic                         cordic_flush_d;
  logic                         done_d;
  logic [CORDIC_DATA_WIDTH-1:0] res_one_d;
  logic [CORDIC_DATA_WIDTH-1:0] res_two_d;
  logic [CORDIC_DATA_WIDTH-1:0] res_three_d;
  logic                         error_d;

  logic                         timeout;
  logic                         lane_adv;
  logic [CORDIC_DATA_WIDTH-1:0] lane_result;
  logic [CORDIC_DATA_WIDTH-1:0] op_next;

  // The watchdog counts cycles since the issue strobe (0 during ISSUE), so a
  // silent core is flushed TIMEOUT_CYCLES cycles after its cordic_start.
  // A done arriving on the timeout cycle takes priority over the timeout.
  assign timeout     = (state_q == S_WAIT) && !cordic_done && (wdog_q == WDOG_LAST);
  assign lane_adv    = (state_q == S_WAIT) && (cordic_done || timeout);
  assign lane_result = cordic_done ? cordic_result : '0;

  always_comb begin
    case (lane_q)
      2'd0:    op_next = op_two_q;
      default: op_next = op_three_q;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else if (clk_en) begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (lane_adv) begin
          state_d = (lane_q == LANE_LAST) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic. Outputs are decoded from the next state so that
  // the registered strobes line up with the state they belong to.
  always_comb begin
    lane_d         = lane_q;
    wdog_d         = wdog_q;
    op_one_d       = op_one_q;
    op_two_d       = op_two_q;
    op_three_d     = op_three_q;
    cordic_x_d     = cordic_x;
    res_one_d      = res_one;
    res_two_d      = res_two;
    res_three_d    = res_three;
    error_d        = error;
    busy_d         = (state_d != S_IDLE);
    cordic_start_d = (state_d == S_ISSUE);
    done_d         = (state_d == S_DONE);
    cordic_flush_d = timeout;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_one_d   = x_one;
          op_two_d   = x_two;
          op_three_d = x_three;
          cordic_x_d = x_one;
          error_d    = 1'b0;
          lane_d     = 2'd0;
          wdog_d     = '0;
        end
      end
      S_ISSUE: begin
        wdog_d = WDOG_ONE;
      end
      S_WAIT: begin
        if (lane_adv) begin
          case (lane_q)
            2'd0:    res_one_d   = lane_result;
            2'd1:    res_two_d   = lane_result;
            default: res_three_d = lane_result;
          endcase
          if (timeout) error_d = 1'b1;
          if (lane_q != LANE_LAST) begin
            lane_d     = lane_q + 2'd1;
            wdog_d     = '0;
            cordic_x_d = op_next;
          end
        end else begin
          wdog_d = wdog_q + WDOG_ONE;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_q       <= 2'd0;
      wdog_q       <= '0;
      op_one_q     <= '0;
      op_two_q     <= '0;
      op_three_q   <= '0;
      busy         <= 1'b0;
      cordic_start <= 1'b0;
      cordic_x     <= '0;
      cordic_flush <= 1'b0;
      done         <= 1'b0;
      res_one      <= '0;
      res_two      <= '0;
      res_three    <= '0;
      error        <= 1'b0;
    end else if (clk_en) begin
      lane_q       <= lane_d;
      wdog_q       <= wdog_d;
      op_one_q     <= op_one_d;
      op_two_q     <= op_two_d;
      op_three_q   <= op_three_d;
      busy         <= busy_d;
      cordic_start <= cordic_start_d;
      cordic_x     <= cordic_x_d;
      cordic_flush <= cordic_flush_d;
      done         <= done_d;
      res_one      <= res_one_d;
      res_two      <= res_two_d;
      res_three    <= res_three_d;
      error        <= error_d;
    end
  end

endmodule
